// File: rtl/mult_batch_engine.sv
// Batch shift-add multiplier: owns a W-bit data memory and, per start handshake,
// multiplies cnt operand pairs (stride 4 words) writing each 2W-bit product back.
module mult_batch_engine #(
    parameter int W  = 32,
    parameter int AW = 9,
    parameter int CW = 7
) (
    input  logic          ck,
    input  logic          rb,
    input  logic          start,
    input  logic          sgn,
    input  logic [CW-1:0] cnt,
    output logic          ready,
    output logic          done,
    output logic [CW-1:0] pidx,
    input  logic          dcen,
    input  logic          dwen,
    input  logic [AW-1:0] dadr,
    input  logic [W-1:0]  dinp,
    output logic [W-1:0]  dout
);
    localparam int DEPTH = 1 << AW;
    localparam int NMAX  = DEPTH / 4;
    localparam int BW    = $clog2(W + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_RDA, S_RDB, S_LATB, S_MUL, S_WRL, S_WRH
    } state_t;

    state_t          state_q, state_d;
    logic            sgn_q, sgn_d, neg_q, neg_d, done_q, done_d;
    logic [CW-1:0]   n_q, n_d, pidx_q, pidx_d;
    logic [W-1:0]    a_q, a_d, rd_q, rd_d, mcand_q, mcand_d, dout_q, dout_d;
    logic [2*W-1:0]  acc_q, acc_d;
    logic [BW-1:0]   bcnt_q, bcnt_d;

    logic [W-1:0]    mem [DEPTH];
    logic            mem_we;
    logic [AW-1:0]   mem_wa, mem_ra, base;
    logic [W-1:0]    mem_wd, mem_rdata;
    logic [2*W-1:0]  prod;
    logic [W:0]      sum;
    logic [W-1:0]    a_abs, b_abs;
    logic            last;

    assign base = AW'(pidx_q) << 2;

    // The host owns the read port only while idle.
    always_comb begin
        mem_ra = dadr;
        case (state_q)
            S_RDA:   mem_ra = base;
            S_RDB:   mem_ra = base + AW'(1);
            default: mem_ra = dadr;
        endcase
    end

    assign mem_rdata = mem[mem_ra];

    assign prod  = neg_q ? -acc_q : acc_q;
    assign sum   = {1'b0, acc_q[2*W-1:W]} + {1'b0, mcand_q};
    assign a_abs = (sgn_q && a_q[W-1])  ? -a_q  : a_q;
    assign b_abs = (sgn_q && rd_q[W-1]) ? -rd_q : rd_q;
    assign last  = ((CW+1)'(pidx_q) + (CW+1)'(1)) >= (CW+1)'(n_q);

    always_comb begin
        state_d = state_q;
        sgn_d   = sgn_q;
        neg_d   = neg_q;
        done_d  = 1'b0;
        n_d     = n_q;
        pidx_d  = pidx_q;
        a_d     = a_q;
        rd_d    = mem_rdata;
        mcand_d = mcand_q;
        dout_d  = dout_q;
        acc_d   = acc_q;
        bcnt_d  = bcnt_q;
        mem_we  = 1'b0;
        mem_wa  = dadr;
        mem_wd  = dinp;
        case (state_q)
            S_IDLE: begin
                mem_we = dcen & dwen;
                if (dcen && !dwen) dout_d = mem_rdata;
                if (start && cnt != '0) begin
                    sgn_d   = sgn;
                    n_d     = (int'(cnt) > NMAX) ? CW'(NMAX) : cnt;
                    pidx_d  = '0;
                    state_d = S_RDA;
                end
            end
            S_RDA: state_d = S_RDB;
            S_RDB: begin
                a_d     = rd_q;
                state_d = S_LATB;
            end
            S_LATB: begin
                mcand_d = a_abs;
                acc_d   = {{W{1'b0}}, b_abs};
                neg_d   = sgn_q & (a_q[W-1] ^ rd_q[W-1]);
                bcnt_d  = BW'(W);
                state_d = S_MUL;
            end
            S_MUL: begin
                // Carry out of the high-half add shifts back in at the top.
                if (acc_q[0]) acc_d = {sum, acc_q[W-1:1]};
                else          acc_d = {1'b0, acc_q[2*W-1:1]};
                bcnt_d = bcnt_q - BW'(1);
                if (bcnt_q == BW'(1)) state_d = S_WRL;
            end
            S_WRL: begin
                mem_we  = 1'b1;
                mem_wa  = base + AW'(2);
                mem_wd  = prod[W-1:0];
                state_d = S_WRH;
            end
            S_WRH: begin
                mem_we = 1'b1;
                mem_wa = base + AW'(3);
                mem_wd = prod[2*W-1:W];
                if (last) begin
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    pidx_d  = pidx_q + CW'(1);
                    state_d = S_RDA;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge ck) begin
        if (mem_we) mem[mem_wa] <= mem_wd;
    end

    always_ff @(posedge ck or negedge rb) begin
        if (!rb) begin
            state_q <= S_IDLE;
            sgn_q   <= 1'b0;
            neg_q   <= 1'b0;
            done_q  <= 1'b0;
            n_q     <= '0;
            pidx_q  <= '0;
            a_q     <= '0;
            rd_q    <= '0;
            mcand_q <= '0;
            dout_q  <= '0;
            acc_q   <= '0;
            bcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            sgn_q   <= sgn_d;
            neg_q   <= neg_d;
            done_q  <= done_d;
            n_q     <= n_d;
            pidx_q  <= pidx_d;
            a_q     <= a_d;
            rd_q    <= rd_d;
            mcand_q <= mcand_d;
            dout_q  <= dout_d;
            acc_q   <= acc_d;
            bcnt_q  <= bcnt_d;
        end
    end

    assign ready = (state_q == S_IDLE);
    assign done  = done_q;
    assign pidx  = pidx_q;
    assign dout  = dout_q;

endmodule

// File: tb/tb_mult_batch_engine.sv
// Bench for mult_batch_engine: W=32 and W=8 instances, directed plus random batches
// checked against an arithmetic product model over a shadow copy of memory.
module tb_mult_batch_engine;
    logic ck = 1'b0;
    always #5 ck = ~ck;

    logic        rb, start, sgn, dcen, dwen, ready, done;
    logic [6:0]  cnt, pidx;
    logic [8:0]  dadr;
    logic [31:0] dinp, dout;

    logic        s8_start, s8_sgn, s8_dcen, s8_dwen, s8_ready, s8_done;
    logic [6:0]  s8_cnt, s8_pidx;
    logic [8:0]  s8_dadr;
    logic [7:0]  s8_dinp, s8_dout;

    mult_batch_engine #(.W(32), .AW(9), .CW(7)) dut (
        .ck(ck), .rb(rb), .start(start), .sgn(sgn), .cnt(cnt), .ready(ready),
        .done(done), .pidx(pidx), .dcen(dcen), .dwen(dwen), .dadr(dadr),
        .dinp(dinp), .dout(dout));

    mult_batch_engine #(.W(8), .AW(9), .CW(7)) dut8 (
        .ck(ck), .rb(rb), .start(s8_start), .sgn(s8_sgn), .cnt(s8_cnt),
        .ready(s8_ready), .done(s8_done), .pidx(s8_pidx), .dcen(s8_dcen),
        .dwen(s8_dwen), .dadr(s8_dadr), .dinp(s8_dinp), .dout(s8_dout));

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] ref_mem [512];
    int          pq [$];
    int          lat, nd;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b,
                                            input logic s);
        longint sa, sb;
        if (s) begin
            sa = {{32{a[31]}}, a};
            sb = {{32{b[31]}}, b};
            return 64'(sa * sb);
        end
        return {32'd0, a} * {32'd0, b};
    endfunction

    task automatic wr(input int addr, input logic [31:0] d);
        @(negedge ck);
        dcen = 1'b1; dwen = 1'b1; dadr = 9'(addr); dinp = d;
        @(negedge ck);
        dcen = 1'b0; dwen = 1'b0;
        ref_mem[addr] = d;
    endtask

    task automatic rd(input int addr, output logic [31:0] d);
        @(negedge ck);
        dcen = 1'b1; dwen = 1'b0; dadr = 9'(addr);
        @(negedge ck);
        d = dout;
        dcen = 1'b0;
    endtask

    // Fold a completed batch into the shadow memory.
    task automatic apply_batch(input logic s, input int c);
        logic [63:0] p;
        for (int k = 0; k < c; k++) begin
            p = ref_mul(ref_mem[4*k], ref_mem[4*k+1], s);
            ref_mem[4*k+2] = p[31:0];
            ref_mem[4*k+3] = p[63:32];
        end
    endtask

    task automatic verify(input int c);
        logic [31:0] d;
        for (int a = 0; a < 4*c; a++) begin
            rd(a, d);
            chk($sformatf("mem[%0d]", a), {32'd0, d}, {32'd0, ref_mem[a]});
        end
    endtask

    // Latency counts edges from the one sampling start to the one after which ready=1.
    task automatic run_batch(input logic s, input int c, input bit disturb);
        int last;
        pq.delete();
        last = -1;
        @(negedge ck);
        start = 1'b1; sgn = s; cnt = 7'(c);
        @(posedge ck);
        lat = 1; nd = 0;
        @(negedge ck);
        start = 1'b0;
        while (1) begin
            if (done) nd++;
            if (ready) break;
            if (int'(pidx) != last) begin
                pq.push_back(int'(pidx));
                last = int'(pidx);
            end
            if (disturb && lat == 5) begin
                dcen = 1'b1; dwen = 1'b1; dadr = 9'd1; dinp = 32'hDEAD;
                start = 1'b1; cnt = 7'd1;
            end else begin
                dcen = 1'b0; dwen = 1'b0; start = 1'b0;
            end
            if (lat >= 4000) break;
            @(posedge ck);
            lat++;
            @(negedge ck);
        end
        dcen = 1'b0; dwen = 1'b0; start = 1'b0;
        chk("latency", 64'(lat), 64'(c * 37 + 1));
        chk("done_pulses", 64'(nd), 64'd1);
        chk("pidx_steps", 64'(pq.size()), 64'(c));
        for (int k = 0; k < pq.size() && k < c; k++)
            chk($sformatf("pidx_seq[%0d]", k), 64'(pq[k]), 64'(k));
        @(negedge ck);
        chk("done_one_cycle", {63'd0, done}, 64'd0);
    endtask

    task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic s,
                        output logic [7:0] lo, output logic [7:0] hi, output int l8);
        @(negedge ck);
        s8_dcen = 1'b1; s8_dwen = 1'b1; s8_dadr = 9'd0; s8_dinp = a;
        @(negedge ck);
        s8_dadr = 9'd1; s8_dinp = b;
        @(negedge ck);
        s8_dcen = 1'b0; s8_dwen = 1'b0;
        s8_start = 1'b1; s8_sgn = s; s8_cnt = 7'd1;
        @(posedge ck);
        l8 = 1;
        @(negedge ck);
        s8_start = 1'b0;
        while (!s8_ready && l8 < 200) begin
            @(posedge ck);
            l8++;
            @(negedge ck);
        end
        s8_dcen = 1'b1; s8_dwen = 1'b0; s8_dadr = 9'd2;
        @(negedge ck);
        lo = s8_dout; s8_dadr = 9'd3;
        @(negedge ck);
        hi = s8_dout; s8_dcen = 1'b0;
    endtask

    logic [31:0] tbl [6] = '{32'h0, 32'h1, 32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFF, 32'h80000001};

    initial begin
        logic [31:0] d, a, b;
        logic [7:0]  lo8, hi8;
        int          c, l8;
        logic        s;

        rb = 1'b0; start = 1'b0; sgn = 1'b0; cnt = '0; dcen = 1'b0; dwen = 1'b0;
        dadr = '0; dinp = '0;
        s8_start = 1'b0; s8_sgn = 1'b0; s8_cnt = '0; s8_dcen = 1'b0; s8_dwen = 1'b0;
        s8_dadr = '0; s8_dinp = '0;
        repeat (3) @(posedge ck);
        @(negedge ck);
        chk("rst_ready", {63'd0, ready}, 64'd1);
        chk("rst_done",  {63'd0, done},  64'd0);
        chk("rst_pidx",  64'(pidx), 64'd0);
        chk("rst_dout",  64'(dout), 64'd0);
        rb = 1'b1;

        // Single unsigned pair.
        wr(0, 32'h1F142570); wr(1, 32'h001200C2);
        run_batch(1'b0, 1, 1'b0); apply_batch(1'b0, 1); verify(1);

        // Sign handling on the same operands and at the most negative value.
        wr(0, 32'hFFFFFFFF); wr(1, 32'h00000002);
        run_batch(1'b1, 1, 1'b0); apply_batch(1'b1, 1); verify(1);
        run_batch(1'b0, 1, 1'b0); apply_batch(1'b0, 1); verify(1);
        wr(0, 32'h80000000); wr(1, 32'h80000000);
        run_batch(1'b1, 1, 1'b0); apply_batch(1'b1, 1); verify(1);

        // Three-pair batch.
        wr(0, 32'd3); wr(1, 32'd5);
        wr(4, 32'hFFFFFFFF); wr(5, 32'hFFFFFFFF);
        wr(8, 32'd0); wr(9, 32'h1234);
        run_batch(1'b0, 3, 1'b0); apply_batch(1'b0, 3); verify(3);

        // Host write and a second start while busy must both be ignored.
        wr(0, 32'd7); wr(1, 32'd9);
        run_batch(1'b0, 1, 1'b1); apply_batch(1'b0, 1); verify(1);

        // start with cnt=0 is a no-op.
        @(negedge ck);
        start = 1'b1; cnt = 7'd0;
        @(negedge ck);
        start = 1'b0;
        chk("cnt0_ready", {63'd0, ready}, 64'd1);
        chk("cnt0_done",  {63'd0, done},  64'd0);
        @(negedge ck);
        chk("cnt0_ready2", {63'd0, ready}, 64'd1);

        // Random batches.
        for (int it = 0; it < 6; it++) begin
            c = $urandom_range(1, 4);
            s = 1'($urandom_range(0, 1));
            for (int k = 0; k < c; k++) begin
                a = ($urandom_range(0, 3) == 0) ? tbl[$urandom_range(0, 5)] : $urandom;
                b = ($urandom_range(0, 3) == 0) ? tbl[$urandom_range(0, 5)] : $urandom;
                wr(4*k, a); wr(4*k+1, b);
            end
            run_batch(s, c, 1'b0); apply_batch(s, c); verify(c);
        end

        // Reset part-way through a two-pair batch.
        wr(0, 32'h12345678); wr(1, 32'h9ABCDEF0); wr(2, 32'h11111111); wr(3, 32'h22222222);
        wr(4, 32'h0000BEEF); wr(5, 32'h00000003); wr(6, 32'h33333333); wr(7, 32'h44444444);
        rd(0, d);
        @(negedge ck);
        start = 1'b1; sgn = 1'b1; cnt = 7'd2;
        @(negedge ck);
        start = 1'b0;
        repeat (9) @(posedge ck);
        @(negedge ck);
        rb = 1'b0;
        #1;
        chk("midrst_ready", {63'd0, ready}, 64'd1);
        chk("midrst_done",  {63'd0, done},  64'd0);
        chk("midrst_pidx",  64'(pidx), 64'd0);
        chk("midrst_dout",  64'(dout), 64'd0);
        @(negedge ck);
        rb = 1'b1;
        verify(2);
        run_batch(1'b1, 2, 1'b0); apply_batch(1'b1, 2); verify(2);

        // Narrow instance.
        run8(8'hFF, 8'hFF, 1'b0, lo8, hi8, l8);
        chk("w8_u_lo", 64'(lo8), 64'h01);
        chk("w8_u_hi", 64'(hi8), 64'hFE);
        chk("w8_u_lat", 64'(l8), 64'd14);
        run8(8'hFF, 8'hFF, 1'b1, lo8, hi8, l8);
        chk("w8_s_lo", 64'(lo8), 64'h01);
        chk("w8_s_hi", 64'(hi8), 64'h00);
        chk("w8_s_lat", 64'(l8), 64'd14);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
